// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: a redirect beats sequential advance, which beats hold.
// Also flags a redirect target that is not word aligned.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned
);
    always_comb begin
        pc_next = pc;
        if (branch_taken)
            pc_next = {branch_target[XLEN-1:2], 2'b00};
        else if (advance)
            pc_next = pc + XLEN'(PC_STEP);
    end

    assign misaligned = branch_taken & (|branch_target[1:0]);
endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: one outstanding imem request, output register to decode,
// and redirect handling that squashes the output and drops a stale response.
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_instr,
    input  logic            decode_ready,
    output logic            flush,
    output logic            misaligned_tgt
);
    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            drop_pending;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            misaligned_d;
    logic            misaligned_q;
    logic            advance;

    assign advance = (state == S_HOLD) & decode_ready;

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc            (pc),
        .advance       (advance),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_next       (pc_next),
        .misaligned    (misaligned_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            drop_pending <= 1'b0;
            out_valid    <= 1'b0;
            out_pc       <= RESET_PC;
            out_instr    <= XLEN'(INSTR_NOP);
            misaligned_q <= 1'b0;
        end else begin
            pc           <= pc_next;
            misaligned_q <= misaligned_d;
            if (branch_taken) begin
                // Redirect wins: squash output; an in-flight response becomes stale.
                out_valid <= 1'b0;
                out_instr <= XLEN'(INSTR_NOP);
                case (state)
                    S_REQ: begin
                        if (imem_req_ready) begin
                            state        <= S_WAIT;
                            drop_pending <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            state        <= S_REQ;
                            drop_pending <= 1'b0;
                        end else begin
                            drop_pending <= 1'b1;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_REQ: begin
                        if (imem_req_ready)
                            state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            if (drop_pending) begin
                                drop_pending <= 1'b0;
                                state        <= S_REQ;
                            end else begin
                                state     <= S_HOLD;
                                out_valid <= 1'b1;
                                out_pc    <= pc;
                                out_instr <= imem_rsp_data;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (decode_ready) begin
                            state     <= S_REQ;
                            out_valid <= 1'b0;
                            out_instr <= XLEN'(INSTR_NOP);
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

    assign imem_req_valid = (state == S_REQ) & ~rst;
    assign imem_req_addr  = pc;
    assign fetch_valid    = out_valid;
    assign fetch_pc       = out_pc;
    assign fetch_instr    = out_instr;
    assign flush          = branch_taken;
    assign misaligned_tgt = misaligned_q;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed redirect scenarios followed by random
// traffic, all checked against an in-order program-counter scoreboard.
module tb_fetch_redirect_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        decode_ready = 1'b0;
    logic        flush;
    logic        misaligned_tgt;

    always #5 clk = ~clk;

    fetch_redirect_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .decode_ready   (decode_ready),
        .flush          (flush),
        .misaligned_tgt (misaligned_tgt)
    );

    int checks = 0;
    int errors = 0;

    // memory model: FIFO of outstanding addresses and the cycle each answers in
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          lat = 1;
    int          cyc = 0;

    // scoreboard: the PC the front end owes decode next
    logic [31:0] exp_pc = RST_PC;
    bit          prev_br = 1'b0;
    bit          prev_rst = 1'b0;
    logic [31:0] prev_tgt = '0;
    logic [31:0] acc_q[$];
    bit          last_acc = 1'b0;
    logic [31:0] last_acc_addr = '0;
    int          idle = 0;
    int          max_idle = 0;
    int          consumed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cycle();
        bit          acc;
        bit          cons;
        logic [31:0] acc_addr;
        if (!rst && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        acc      = imem_req_valid & imem_req_ready;
        acc_addr = imem_req_addr;
        cons     = fetch_valid & decode_ready;
        if (rst) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            exp_pc  = RST_PC;
            prev_br = 1'b0;
            idle    = 0;
        end else begin
            chk("flush", 32'(flush), 32'(branch_taken));
            if (prev_rst) begin
                chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
                chk("rst_fetch_pc", fetch_pc, RST_PC);
                chk("rst_fetch_instr", fetch_instr, NOP);
            end
            chk("misaligned", 32'(misaligned_tgt), 32'(prev_br && (prev_tgt[1:0] != 2'b00)));
            if (prev_br)
                chk("squash_after_redirect", 32'(fetch_valid), 32'd0);
            if (fetch_valid) begin
                chk("fetch_pc", fetch_pc, exp_pc);
                chk("fetch_instr", fetch_instr, mem_word(exp_pc));
            end else begin
                chk("nop_when_invalid", fetch_instr, NOP);
            end
            if (imem_req_valid) begin
                chk("req_addr", imem_req_addr, exp_pc);
                chk("one_outstanding", 32'(mem_addr_q.size()), 32'd0);
            end
            if (acc)
                acc_q.push_back(acc_addr);
            if (branch_taken)
                exp_pc = branch_target & ~32'h3;
            else if (cons) begin
                exp_pc   = exp_pc + 32'd4;
                consumed++;
            end
            prev_br  = branch_taken;
            prev_tgt = branch_target;
            idle     = (cons || branch_taken) ? 0 : idle + 1;
            if (idle > max_idle)
                max_idle = idle;
        end
        prev_rst      = rst;
        last_acc      = acc;
        last_acc_addr = acc_addr;
        @(posedge clk);
        if (rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (imem_rsp_valid) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (acc) begin
                mem_addr_q.push_back(acc_addr);
                mem_due_q.push_back(cyc + lat);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            cycle();
    endtask

    task automatic wait_fv(input string tag);
        int k;
        k = 0;
        while (!fetch_valid && k < 50) begin
            cycle();
            k++;
        end
        chk(tag, 32'(fetch_valid), 32'd1);
    endtask

    task automatic wait_acc(input string tag);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!last_acc && k < 50);
        chk(tag, 32'(last_acc), 32'd1);
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        int          k;

        imem_req_ready = 1'b1;
        decode_ready   = 1'b1;
        @(negedge clk);
        run(2);
        rst = 1'b0;

        // sequential fetch with 1-cycle memory
        acc_q.delete();
        run(9);
        chk("t1_acc_count", 32'(acc_q.size() >= 3), 32'd1);
        chk("t1_addr0", acc_q[0], 32'h0);
        chk("t1_addr1", acc_q[1], 32'h4);
        chk("t1_addr2", acc_q[2], 32'h8);

        // decode stall holds the output and blocks new requests
        decode_ready = 1'b0;
        wait_fv("t2_reach_hold");
        held_pc    = fetch_pc;
        held_instr = fetch_instr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_valid_held", 32'(fetch_valid), 32'd1);
            chk("t2_pc_held", fetch_pc, held_pc);
            chk("t2_instr_held", fetch_instr, held_instr);
            chk("t2_no_req", 32'(imem_req_valid), 32'd0);
        end
        decode_ready = 1'b1;
        acc_q.delete();
        wait_acc("t2_acc");
        chk("t2_next_addr", acc_q[0], held_pc + 32'd4);

        // redirect while waiting; late response must be dropped
        lat = 4;
        wait_acc("t3_acc");
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        lat = 1;
        cycle();
        branch_taken = 1'b0;
        acc_q.delete();
        for (int i = 0; i < 4; i++) begin
            chk("t3_no_fetch", 32'(fetch_valid), 32'd0);
            cycle();
        end
        chk("t3_acc_count", 32'(acc_q.size()), 32'd1);
        chk("t3_addr", acc_q[0], 32'h100);

        // redirect coinciding with the response
        lat = 2;
        wait_acc("t4_acc");
        cycle();
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        cycle();
        branch_taken = 1'b0;
        lat = 1;
        acc_q.delete();
        wait_fv("t4_fv");
        chk("t4_fetch_pc", fetch_pc, 32'h200);
        chk("t4_acc_count", 32'(acc_q.size()), 32'd1);
        chk("t4_addr", acc_q[0], 32'h200);

        // misaligned redirect from hold with a same-cycle decode handshake
        decode_ready = 1'b0;
        wait_fv("t5_hold");
        decode_ready  = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        cycle();
        branch_taken = 1'b0;
        acc_q.delete();
        chk("t5_misaligned_pulse", 32'(misaligned_tgt), 32'd1);
        cycle();
        chk("t5_addr", acc_q[0], 32'h100);
        chk("t5_pulse_ends", 32'(misaligned_tgt), 32'd0);

        // PC wrap, then reset in the middle of a wait
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        cycle();
        branch_taken = 1'b0;
        acc_q.delete();
        run(8);
        chk("t6_top_addr", acc_q[0], 32'hFFFF_FFFC);
        chk("t6_wrap_addr", acc_q[1], 32'h0);
        lat = 5;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!(last_acc && last_acc_addr != 32'h0) && k < 50);
        chk("t6_nonzero_acc", 32'(last_acc && last_acc_addr != 32'h0), 32'd1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        lat = 1;
        acc_q.delete();
        wait_acc("t6_acc_after_rst");
        chk("t6_addr_after_rst", acc_q[0], RST_PC);

        // random traffic
        max_idle = 0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            decode_ready   = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(1, 4);
            branch_taken   = ($urandom_range(0, 15) == 0);
            branch_target  = $urandom;
            if ($urandom_range(0, 1) == 1)
                branch_target[1:0] = 2'b00;
            rst = ($urandom_range(0, 499) == 0);
            if (rst)
                branch_taken = 1'b0;
            cycle();
        end
        rst          = 1'b0;
        branch_taken = 1'b0;
        chk("rand_liveness", 32'(max_idle <= 100), 32'd1);
        chk("rand_progress", 32'(consumed > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
